// File: rtl/dcache_pkg.sv
// Shared types and funct3 encodings for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // MEM-stage funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dcache_mem_if.sv
// Single-word valid/ready memory port between the cache (master) and data memory (slave).
interface dcache_mem_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [3:0]       wstrb;
    logic             ready;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/dcache_load_align.sv
// Picks the byte/half/word out of a cached word and extends it for the load type.
// Byte lanes assume a 32-bit word.
module dcache_load_align
    import dcache_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [1:0]       offset_i,
    input  logic [2:0]       mode_i,
    output logic [WIDTH-1:0] data_o
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    // Lane select (halfwords force-aligned by ignoring offset bit 0), then extension
    always_comb begin
        byte_sel = word_i[8*offset_i +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (mode_i)
            F3_B:    data_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {{(WIDTH-8){1'b0}}, byte_sel};
            F3_H:    data_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
            F3_HU:   data_o = {{(WIDTH-16){1'b0}}, half_sel};
            default: data_o = word_i;   // LW and any unlisted mode: whole word
        endcase
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Loads hit combinationally; misses refill a whole line one word per beat;
// every store is written through to memory and merged into the line on a hit.
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic [2:0]       cpu_mode,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             stall,
    dcache_mem_if.master     mem
);

    localparam int WRD_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WIDTH - 2 - WRD_W - IDX_W;

    // Address split
    logic [1:0]       off;
    logic [WRD_W-1:0] word;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;

    assign off   = cpu_addr[1:0];
    assign word  = cpu_addr[2 +: WRD_W];
    assign index = cpu_addr[2+WRD_W +: IDX_W];
    assign tag   = cpu_addr[WIDTH-1 -: TAG_W];

    // Control state (async reset)
    state_t           state_q, state_d;
    logic [WRD_W-1:0] beat_q, beat_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic             done_q, done_d;   // store just completed; let the pipeline advance

    // Storage (no reset; valid bits guard it)
    logic [WIDTH-1:0] line_q [SETS][LINE_WORDS];
    logic [TAG_W-1:0] tag_q  [SETS];

    logic             hit;
    logic             last_beat;
    logic             fill_en;
    logic             merge_en;
    logic             rdata_en;
    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] st_data;
    logic [3:0]       st_strb;

    assign hit       = valid_q[index] && (tag_q[index] == tag);
    assign last_beat = (beat_q == WRD_W'(LINE_WORDS - 1));

    dcache_load_align #(.WIDTH(WIDTH)) u_align (
        .word_i   (line_q[index][word]),
        .offset_i (off),
        .mode_i   (cpu_mode),
        .data_o   (aligned)
    );

    assign cpu_rdata = rdata_en ? aligned : '0;

    // Store lane placement: data replicated across lanes, strobes pick the live ones
    always_comb begin
        case (cpu_mode[1:0])
            2'b00: begin
                st_strb = 4'b0001 << off;
                st_data = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << {off[1], 1'b0};
                st_data = {2{cpu_wdata[15:0]}};
            end
            default: begin
                st_strb = 4'hF;
                st_data = cpu_wdata;
            end
        endcase
    end

    // FSM next-state and outputs
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        stall     = 1'b0;
        fill_en   = 1'b0;
        merge_en  = 1'b0;
        rdata_en  = 1'b0;
        mem.req   = 1'b0;
        mem.we    = 1'b0;
        mem.addr  = '0;
        mem.wdata = '0;
        mem.wstrb = 4'h0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (cpu_we) begin
                        // store wins over a simultaneous load
                        if (!done_q) begin
                            stall   = 1'b1;
                            state_d = WRITE;
                        end
                    end else if (cpu_re) begin
                        if (hit) begin
                            rdata_en = 1'b1;
                        end else begin
                            stall          = 1'b1;
                            beat_d         = '0;
                            valid_d[index] = 1'b0;   // line is being overwritten
                            state_d        = REFILL;
                        end
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem.req  = 1'b1;
                mem.addr = {tag, index, beat_q, 2'b00};
                if (mem.ready) begin
                    fill_en = 1'b1;
                    beat_d  = beat_q + WRD_W'(1);
                    if (last_beat) begin
                        valid_d[index] = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            WRITE: begin
                stall     = 1'b1;
                mem.req   = 1'b1;
                mem.we    = 1'b1;
                mem.addr  = {cpu_addr[WIDTH-1:2], 2'b00};
                mem.wdata = st_data;
                mem.wstrb = st_strb;
                if (mem.ready) begin
                    merge_en = hit;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset aborts any refill or write in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Line data and tag updates from refill beats and store-hit merges
    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_q[index][beat_q] <= mem.rdata;
            if (last_beat) begin
                tag_q[index] <= tag;
            end
        end
        if (merge_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_strb[b]) begin
                    line_q[index][word][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct: drivers push expected memory beats and
// load results; a negedge monitor pops and compares as the DUT presents them.
module tb_dcache_direct;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_mode;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        ready_drv;

    always #5 clk = ~clk;

    dcache_mem_if #(.WIDTH(32)) mem ();

    // memory model: every word holds its own address
    assign mem.ready = ready_drv;
    assign mem.rdata = mem.addr;

    dcache_direct #(.WIDTH(32), .SETS(16), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_mode  (cpu_mode),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem       (mem)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    beat_t       mem_q[$];
    logic [31:0] load_q[$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_refill(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        for (int i = 0; i < 4; i++) mem_q.push_back({1'b0, base + 32'(4*i), 32'h0, 4'h0});
    endtask

    // Monitor: compares memory beats and completed loads
    beat_t       mon_e;
    logic [31:0] mon_m;
    logic [31:0] mon_l;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem.req && mem.ready) begin
                if (mem_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_mem_beat: got addr %h we %0d, expected none", mem.addr, mem.we);
                end else begin
                    mon_e = mem_q.pop_front();
                    check("mem_we", 32'(mem.we), 32'(mon_e.we));
                    check("mem_addr", mem.addr, mon_e.addr);
                    if (mon_e.we) begin
                        check("mem_wstrb", 32'(mem.wstrb), 32'(mon_e.strb));
                        mon_m = {{8{mon_e.strb[3]}}, {8{mon_e.strb[2]}}, {8{mon_e.strb[1]}}, {8{mon_e.strb[0]}}};
                        check("mem_wdata", mem.wdata & mon_m, mon_e.wdata & mon_m);
                    end
                end
            end
            if (cpu_re && !cpu_we && !stall) begin
                if (load_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_load: got %h, expected none", cpu_rdata);
                end else begin
                    mon_l = load_q.pop_front();
                    check("cpu_rdata", cpu_rdata, mon_l);
                end
            end
        end
    end

    // Wait for stall to drop, then retire the request on the next edge
    task automatic wait_release(output int sc);
        sc = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (!stall) begin
                @(posedge clk);
                #1;
                cpu_re = 1'b0;
                cpu_we = 1'b0;
                return;
            end
            sc++;
        end
        tests++;
        fails++;
        $display("FAIL stall_timeout: got stall still 1 after 64 cycles, expected release");
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    // Load: a miss costs the detect cycle plus four refill beats
    task automatic do_load(input logic [31:0] a, input logic [2:0] mode,
                           input logic [31:0] exp, input bit miss);
        int sc;
        if (miss) push_refill(a);
        load_q.push_back(exp);
        cpu_addr = a;
        cpu_mode = mode;
        cpu_re   = 1'b1;
        wait_release(sc);
        check("load_stall_cycles", 32'(sc), miss ? 32'd5 : 32'd0);
    endtask

    // Store: detect cycle plus one write beat, also with a load raised alongside
    task automatic do_store(input logic [31:0] a, input logic [2:0] mode, input logic [31:0] d,
                            input logic [31:0] exp_d, input logic [3:0] exp_s, input bit with_re);
        int sc;
        mem_q.push_back({1'b1, {a[31:2], 2'b00}, exp_d, exp_s});
        cpu_addr  = a;
        cpu_mode  = mode;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        cpu_re    = with_re;
        wait_release(sc);
        check("store_stall_cycles", 32'(sc), 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        rst       = 1'b1;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_mode  = F3_W;
        ready_drv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem.req), 32'd0);
        check("rst_mem_we", 32'(mem.we), 32'd0);
        check("rst_mem_addr", mem.addr, 32'd0);
        check("rst_mem_wstrb", 32'(mem.wstrb), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // cold miss, then a hit in the same line
        do_load(32'h100, F3_W, 32'h100, 1'b1);
        do_load(32'h108, F3_W, 32'h108, 1'b0);

        // byte store on a hit line, then extended reads of the merged word
        do_store(32'h101, F3_B, 32'h0000_00AB, 32'h0000_AB00, 4'b0010, 1'b0);
        do_load(32'h101, F3_BU, 32'h0000_00AB, 1'b0);
        do_load(32'h101, F3_B,  32'hFFFF_FFAB, 1'b0);
        do_load(32'h100, F3_W,  32'h0000_AB00, 1'b0);
        do_load(32'h100, F3_HU, 32'h0000_AB00, 1'b0);
        do_load(32'h101, F3_H,  32'hFFFF_AB00, 1'b0);   // offset bit 0 ignored
        do_store(32'h102, F3_H, 32'h0000_1234, 32'h1234_0000, 4'b1100, 1'b0);
        do_load(32'h100, F3_W,  32'h1234_AB00, 1'b0);
        do_load(32'h103, F3_W,  32'h1234_AB00, 1'b0);   // word force-aligned
        do_load(32'h104, 3'b011, 32'h0000_0104, 1'b0);  // unlisted mode: whole word

        // store and load together: store wins
        do_store(32'h10B, F3_B, 32'h0000_005A, 32'h5A00_0000, 4'b1000, 1'b1);
        do_load(32'h108, F3_W, 32'h5A00_0108, 1'b0);

        // store miss does not allocate
        do_store(32'h400, F3_W, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF, 1'b0);
        do_load(32'h400, F3_W, 32'h0000_0400, 1'b1);

        // refill with memory not ready for 5 cycles
        ready_drv = 1'b0;
        push_refill(32'h200);
        load_q.push_back(32'h200);
        cpu_addr = 32'h200;
        cpu_mode = F3_W;
        cpu_re   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("wait_stall", 32'(stall), 32'd1);
            if (k > 0) begin
                check("wait_mem_req", 32'(mem.req), 32'd1);
                check("wait_mem_addr", mem.addr, 32'h200);
            end
        end
        @(posedge clk);
        #1;
        ready_drv = 1'b1;
        wait_release(sc);
        check("ready_stall_cycles", 32'(sc), 32'd4);

        // reset in the middle of a refill
        mem_q.push_back({1'b0, 32'h300, 32'h0, 4'h0});
        mem_q.push_back({1'b0, 32'h304, 32'h0, 4'h0});
        cpu_addr = 32'h300;
        cpu_mode = F3_W;
        cpu_re   = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        cpu_re = 1'b0;
        #1;
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_mem_req", 32'(mem.req), 32'd0);
        check("abort_cpu_rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_load(32'h300, F3_W, 32'h300, 1'b1);
        do_load(32'h100, F3_W, 32'h1234_AB00 & 32'h0 | 32'h100, 1'b1);  // reset invalidated all lines

        repeat (2) @(posedge clk);
        check("mem_queue_left", 32'(mem_q.size()), 32'd0);
        check("load_queue_left", 32'(load_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
